core_muldiv: RTL and testbench

CORE_MULDIV -- requirements
Module: core_muldiv

---
 rtl/core_pkg.sv | 29 ++
 rtl/core_muldiv.sv | 156 +++++++++++++++
 tb/tb_core_muldiv.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: RV32M funct3 encodings and the mul/div unit state machine.
package core_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } muldiv_state_e;

   function automatic logic op_is_div(input muldiv_op_e op);
      return op[2];
   endfunction

   function automatic logic op_is_rem(input muldiv_op_e op);
      return op[2] & op[1];
   endfunction

endpackage

// File: rtl/core_muldiv.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, sign handled by
// magnitude arithmetic plus a final two's-complement fix-up.
module core_muldiv
   import core_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_value
);

   muldiv_state_e state;
   muldiv_op_e    op_q;
   logic [63:0]   acc;
   logic [31:0]   opnd;
   logic          neg_q;
   logic [4:0]    cnt;
   logic [31:0]   result_q;

   muldiv_op_e    req_op_e;
   logic          a_signed, b_signed;
   logic          a_neg, b_neg, req_neg;
   logic [31:0]   a_mag, b_mag;
   logic          div_zero, div_ovf, accept;
   logic [31:0]   special_res;

   logic [32:0]   add_x, add_y, add_s;
   logic          sub_ok;
   logic [63:0]   acc_nxt;
   logic [63:0]   prod;
   logic [31:0]   quo, rem;
   logic [31:0]   fin_res;

   assign req_op_e = muldiv_op_e'(req_op);

   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (req_op_e)
         OP_MULH, OP_DIV, OP_REM: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         OP_MULHSU: a_signed = 1'b1;
         default: ;
      endcase
   end

   assign a_neg   = a_signed & req_a[31];
   assign b_neg   = b_signed & req_b[31];
   assign a_mag   = a_neg ? (~req_a + 32'd1) : req_a;
   assign b_mag   = b_neg ? (~req_b + 32'd1) : req_b;
   assign req_neg = (req_op_e == OP_REM) ? a_neg : (a_neg ^ b_neg);

   assign div_zero = op_is_div(req_op_e) && (req_b == '0);
   assign div_ovf  = ((req_op_e == OP_DIV) || (req_op_e == OP_REM))
                     && (req_a == 32'h8000_0000) && (req_b == '1);
   assign accept   = req_valid & req_ready & ~flush;

   always_comb begin
      special_res = '0;
      if (div_zero)
         special_res = op_is_rem(req_op_e) ? req_a : '1;
      else if (!op_is_rem(req_op_e))
         special_res = 32'h8000_0000;
   end

   // One shared 33-bit adder: multiply adds opnd to the upper half, divide
   // trial-subtracts opnd from the upper half shifted left by one.
   assign add_x = op_is_div(op_q) ? acc[63:31] : {1'b0, acc[63:32]};
   assign add_y = {1'b0, opnd};
   assign add_s = op_is_div(op_q) ? (add_x - add_y) : (add_x + add_y);
   assign sub_ok = acc[63] | ~add_s[32];

   always_comb begin
      acc_nxt = acc;
      if (op_is_div(op_q))
         acc_nxt = sub_ok ? {add_s[31:0], acc[30:0], 1'b1} : {acc[62:0], 1'b0};
      else
         acc_nxt = acc[0] ? {add_s, acc[31:1]} : {1'b0, acc[63:1]};
   end

   assign prod = neg_q ? (~acc_nxt + 64'd1) : acc_nxt;
   assign quo  = neg_q ? (~acc_nxt[31:0] + 32'd1) : acc_nxt[31:0];
   assign rem  = neg_q ? (~acc_nxt[63:32] + 32'd1) : acc_nxt[63:32];

   always_comb begin
      fin_res = '0;
      case (op_q)
         OP_MUL:                       fin_res = prod[31:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod[63:32];
         OP_DIV, OP_DIVU:              fin_res = quo;
         default:                      fin_res = rem;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         op_q     <= OP_MUL;
         acc      <= '0;
         opnd     <= '0;
         neg_q    <= 1'b0;
         cnt      <= '0;
         result_q <= '0;
      end else if (flush) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q  <= req_op_e;
                  neg_q <= req_neg;
                  opnd  <= b_mag;
                  cnt   <= '0;
                  if (div_zero || div_ovf) begin
                     result_q <= special_res;
                     state    <= ST_DONE;
                  end else begin
                     acc   <= {32'd0, a_mag};
                     state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               acc <= acc_nxt;
               cnt <= cnt + 5'd1;
               // Sign fix-up is folded into the final step so the result
               // is registered on the same edge that enters DONE.
               if (cnt == 5'd31) begin
                  result_q <= fin_res;
                  state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (resp_ready)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready  = (state == ST_IDLE);
   assign resp_valid = (state == ST_DONE);
   assign resp_value = (state == ST_DONE) ? result_q : '0;

endmodule

// File: tb/tb_core_muldiv.sv
// Directed self-checking bench for core_muldiv; the accept edge counts as edge 1.
module tb_core_muldiv;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_value;

   int nerr;
   int nchecks;

   core_muldiv dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_value (resp_value)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat,
                         input logic [31:0] exp_val, input int hold);
      int edges;
      @(negedge clk);
      check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      edges = 1;
      while (!resp_valid && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
      check({tag, ".lat"}, 32'(edges), 32'(exp_lat));
      check({tag, ".val"}, resp_value, exp_val);
      check({tag, ".busy"}, {31'd0, req_ready}, 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, ".hold_valid"}, {31'd0, resp_valid}, 32'd1);
         check({tag, ".hold_val"}, resp_value, exp_val);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check({tag, ".drain_valid"}, {31'd0, resp_valid}, 32'd0);
      check({tag, ".drain_val"}, resp_value, 32'd0);
   endtask

   task automatic no_resp_window(input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         seen = seen | resp_valid;
      end
      check(tag, {31'd0, seen}, 32'd0);
   endtask

   initial begin
      nerr       = 0;
      nchecks    = 0;
      rst_n      = 1'b1;
      flush      = 1'b0;
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      req_op     = 3'd0;
      req_a      = '0;
      req_b      = '0;
      #2 rst_n = 1'b0;
      #1;
      check("rst.ready", {31'd0, req_ready}, 32'd1);
      check("rst.valid", {31'd0, resp_valid}, 32'd0);
      check("rst.value", resp_value, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("mul",    3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 33, 32'hFFFF_FFEB, 0);
      run_op("mulh",   3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFF, 0);
      run_op("mulhu",  3'd3, 32'h0000_0007, 32'hFFFF_FFFD, 33, 32'h0000_0006, 0);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFF, 0);
      run_op("div",    3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFD, 0);
      run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF, 0);
      run_op("divu",   3'd5, 32'd100,       32'd7,         33, 32'd14,        0);
      run_op("remu",   3'd7, 32'd100,       32'd7,         33, 32'd2,         0);
      run_op("divu0",  3'd5, 32'd5,         32'd0,         1,  32'hFFFF_FFFF, 0);
      run_op("remu0",  3'd7, 32'd5,         32'd0,         1,  32'd5,         0);
      run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1,  32'h8000_0000, 0);
      run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1,  32'h0000_0000, 0);
      run_op("hold",   3'd0, 32'd12345,     32'd1000,      33, 32'd12345000,  4);

      // Flush during CALC cycle 10.
      @(negedge clk);
      req_op = 3'd5; req_a = 32'd100; req_b = 32'd7; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush.valid", {31'd0, resp_valid}, 32'd0);
      check("flush.idle",  {31'd0, req_ready},  32'd1);
      no_resp_window("flush.noresp");

      // Flush wins over a simultaneous request.
      @(negedge clk);
      req_op = 3'd0; req_a = 32'd3; req_b = 32'd5; req_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b0;
      check("flushreq.idle", {31'd0, req_ready}, 32'd1);
      no_resp_window("flushreq.noresp");

      // Reset asserted at CALC cycle 5.
      @(negedge clk);
      req_op = 3'd3; req_a = 32'hDEAD_BEEF; req_b = 32'h1234_5678; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      check("midrst.ready", {31'd0, req_ready}, 32'd1);
      check("midrst.valid", {31'd0, resp_valid}, 32'd0);
      check("midrst.value", resp_value, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      no_resp_window("midrst.noresp");

      run_op("recover", 3'd0, 32'd3, 32'd5, 33, 32'd15, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

endmodule
